// File: rtl/shr_host_driver.sv
// Host-side driver for the serial shift-register test interface: shifts a command word out on di,
// strobes the target, then captures the target's response word from its serial output.
module shr_host_driver #(
    parameter int DIN_N  = 8,
    parameter int DOUT_N = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIN_N-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DOUT_N-1:0] rsp_data,
    output logic              di,
    output logic              stb,
    input  logic              sdo,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_cnt
);

    localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int BC_W  = $clog2(MAX_N) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STROBE,
        CAPTURE,
        RSP_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [DIN_N-1:0]   tx_q, tx_nxt;
    logic [DOUT_N-1:0]  rx_q, rx_nxt, rx_shift;
    logic [BC_W-1:0]    bit_q, bit_nxt;
    logic               di_nxt, stb_nxt;
    logic               rsp_load;
    logic [DOUT_N-1:0]  rsp_load_data;
    logic               rsp_take, slot_free;

    // The response slot can take a new word when empty or when its current word leaves this cycle.
    assign rsp_take  = rsp_valid && rsp_ready;
    assign slot_free = !rsp_valid || rsp_ready;
    assign rx_shift  = DOUT_N'({rx_q, sdo});

    // Ready is gated by reset so no command is offered a handshake while reset is held.
    assign cmd_ready = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tx_nxt        = tx_q;
        rx_nxt        = rx_q;
        bit_nxt       = bit_q;
        di_nxt        = 1'b0;
        stb_nxt       = 1'b0;
        rsp_load      = 1'b0;
        rsp_load_data = rx_shift;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    // di is registered, so the MSB must leave on the accept edge itself.
                    state_nxt = SHIFT;
                    di_nxt    = cmd_data[DIN_N-1];
                    tx_nxt    = DIN_N'({cmd_data, 1'b0});
                    bit_nxt   = '0;
                end
            end
            SHIFT: begin
                if (bit_q == BC_W'(DIN_N - 1)) begin
                    state_nxt = STROBE;
                    stb_nxt   = 1'b1;
                end else begin
                    di_nxt  = tx_q[DIN_N-1];
                    tx_nxt  = DIN_N'({tx_q, 1'b0});
                    bit_nxt = bit_q + BC_W'(1);
                end
            end
            STROBE: begin
                state_nxt = CAPTURE;
                bit_nxt   = '0;
            end
            CAPTURE: begin
                rx_nxt = rx_shift;
                if (bit_q == BC_W'(DOUT_N - 1)) begin
                    if (slot_free) begin
                        rsp_load  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RSP_WAIT;
                    end
                end else begin
                    bit_nxt = bit_q + BC_W'(1);
                end
            end
            RSP_WAIT: begin
                if (slot_free) begin
                    rsp_load      = 1'b1;
                    rsp_load_data = rx_q;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            di        <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            txn_cnt   <= '0;
        end else begin
            tx_q  <= tx_nxt;
            rx_q  <= rx_nxt;
            bit_q <= bit_nxt;
            di    <= di_nxt;
            stb   <= stb_nxt;
            if (rsp_load) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rsp_load_data;
            end else if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_take) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shr_host_driver.sv
// Self-checking bench for shr_host_driver: emulated target shift registers, a cycle-level
// transaction model, constant vector table, hand-written corner sequences and random traffic.
`timescale 1ns/1ps
module tb_shr_host_driver;

    localparam int DIN_N  = 8;
    localparam int DOUT_N = 8;
    localparam int CNT_W  = 16;
    localparam int LAT    = DIN_N + 1 + DOUT_N;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic [DIN_N-1:0]  cmd_data;
    logic              rsp_ready;
    logic              sdo;
    logic              cmd_ready, rsp_valid, di, stb, busy;
    logic [DOUT_N-1:0] rsp_data;
    logic [CNT_W-1:0]  txn_cnt;
    logic              cmd_ready2, rsp_valid2, di2, stb2, busy2;
    logic [DOUT_N-1:0] rsp_data2;
    logic [1:0]        txn_cnt2;

    int checks   = 0;
    int failures = 0;

    shr_host_driver #(.DIN_N(DIN_N), .DOUT_N(DOUT_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .di(di), .stb(stb), .sdo(sdo), .busy(busy), .txn_cnt(txn_cnt)
    );

    shr_host_driver #(.DIN_N(DIN_N), .DOUT_N(DOUT_N), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .di(di2), .stb(stb2), .sdo(sdo), .busy(busy2), .txn_cnt(txn_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Emulated minitest target: din shift register, din latch and dout shift register.
    logic [DIN_N-1:0]  t_sin, t_din;
    logic [DOUT_N-1:0] t_sout;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_sin  <= '0;
            t_din  <= '0;
            t_sout <= '0;
        end else begin
            t_sin <= {t_sin[DIN_N-2:0], di};
            if (stb) begin
                t_din  <= t_sin;
                t_sout <= t_din ^ 8'hFF;
            end else begin
                t_sout <= {t_sout[DOUT_N-2:0], 1'b0};
            end
        end
    end
    assign sdo = t_sout[DOUT_N-1];

    // Transaction model: countdown from accept to completion, response slot, and a din chain.
    bit          m_idle, m_wait, m_rv;
    int          m_left;
    logic [7:0]  m_rd, m_pend, m_prev, m_cmd;
    int unsigned m_cnt;

    task automatic model_reset();
        m_idle = 1'b1; m_wait = 1'b0; m_rv = 1'b0; m_left = 0;
        m_rd = '0; m_pend = '0; m_prev = '0; m_cmd = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit take, free, nrv;
        logic [7:0] nrd;
        take = m_rv && rsp_ready;
        free = !m_rv || rsp_ready;
        nrv  = m_rv && !take;
        nrd  = m_rd;
        if (take) m_cnt++;
        if (m_idle) begin
            if (cmd_valid) begin
                m_idle = 1'b0;
                m_left = LAT;
                m_pend = m_prev ^ 8'hFF;
                m_prev = cmd_data;
                m_cmd  = cmd_data;
            end
        end else if (m_wait) begin
            if (free) begin
                nrv = 1'b1; nrd = m_pend; m_idle = 1'b1; m_wait = 1'b0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (free) begin
                    nrv = 1'b1; nrd = m_pend; m_idle = 1'b1;
                end else begin
                    m_wait = 1'b1;
                end
            end
        end
        m_rv = nrv;
        m_rd = nrd;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exp_stb, exp_di;
        exp_stb = (!m_idle && !m_wait && m_left == DOUT_N + 1);
        exp_di  = 1'b0;
        if (!m_idle && !m_wait && m_left > DOUT_N + 1) exp_di = m_cmd[m_left - DOUT_N - 2];
        check_output("cmd_ready", cmd_ready, m_idle);
        check_output("busy", busy, !m_idle);
        check_output("stb", stb, exp_stb);
        check_output("di", di, exp_di);
        check_output("rsp_valid", rsp_valid, m_rv);
        check_output("rsp_data", rsp_data, m_rd);
        check_output("txn_cnt", txn_cnt, 16'(m_cnt));
        check_output("cmd_ready2", cmd_ready2, m_idle);
        check_output("busy2", busy2, !m_idle);
        check_output("stb2", stb2, exp_stb);
        check_output("di2", di2, exp_di);
        check_output("rsp_valid2", rsp_valid2, m_rv);
        check_output("rsp_data2", rsp_data2, m_rd);
        check_output("txn_cnt2", txn_cnt2, 2'(m_cnt));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_stimulus(input logic cv, input logic [7:0] cd, input logic rr);
        cmd_valid = cv;
        cmd_data  = cd;
        rsp_ready = rr;
        step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_cmd_ready", cmd_ready, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_di", di, 0);
        check_output("rst_stb", stb, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_rsp_data", rsp_data, 0);
        check_output("rst_txn_cnt", txn_cnt, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // One full transaction with constant expectations on serial data, strobe count and latency.
    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] exp_rsp, input bit noisy);
        int cyc;
        int stb_cnt;
        logic [DIN_N-1:0] di_bits;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            apply_stimulus(1'b0, cmd_data, rsp_ready);
            cyc++;
        end
        check_output("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        step();
        di_bits = '0;
        di_bits[DIN_N-1] = di;
        stb_cnt = 0;
        cyc = 0;
        while (!rsp_valid && cyc < LAT + 10) begin
            if (noisy) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_data  = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            cyc++;
            if (cyc < DIN_N) di_bits[DIN_N-1-cyc] = di;
            if (stb) stb_cnt++;
        end
        cmd_valid = 1'b0;
        check_output("di_serial", di_bits, cmd);
        check_output("stb_pulses", stb_cnt, 1);
        check_output("latency", cyc, LAT);
        check_output("rsp_vec", rsp_data, exp_rsp);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] rsp;
        bit         noisy;
    } vec_t;

    vec_t       vecs[8];
    logic [1:0] t6_seq[5];
    logic [7:0] t6_prev, t6_cmd;

    initial begin
        vecs[0] = '{8'hA5, 8'hFF, 1'b0};
        vecs[1] = '{8'h3C, 8'h5A, 1'b0};
        vecs[2] = '{8'h00, 8'hC3, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{8'h81, 8'h00, 1'b0};
        vecs[5] = '{8'h7E, 8'h7E, 1'b0};
        vecs[6] = '{8'h5C, 8'h81, 1'b1};
        vecs[7] = '{8'hC6, 8'hA3, 1'b1};
        t6_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();

        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].cmd, vecs[i].rsp, vecs[i].noisy);
        end
        step();

        // Two transactions with the consumer stalled: the driver must park and hold the first word.
        rsp_ready = 1'b0;
        run_txn(8'h11, 8'h39, 1'b0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h22;
        step();
        cmd_valid = 1'b0;
        repeat (LAT + 4) step();
        check_output("t3_held", rsp_data, 8'h39);
        check_output("t3_cmd_ready", cmd_ready, 0);
        check_output("t3_busy", busy, 1);
        rsp_ready = 1'b1;
        step();
        check_output("t3_second", rsp_data, 8'hEE);
        check_output("t3_valid", rsp_valid, 1);
        check_output("t3_ready_back", cmd_ready, 1);
        step();
        check_output("t3_drained", rsp_valid, 0);

        // Reset in the middle of the shift phase.
        cmd_valid = 1'b1;
        cmd_data  = 8'hC3;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_output("t4_di", di, 0);
        check_output("t4_stb", stb, 0);
        check_output("t4_rsp_valid", rsp_valid, 0);
        check_output("t4_txn_cnt", txn_cnt, 0);
        check_output("t4_busy", busy, 0);
        check_output("t4_cmd_ready", cmd_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(8'h81, 8'hFF, 1'b0);
        step();

        // Narrow counter wrap on the second instance.
        do_reset();
        rsp_ready = 1'b1;
        t6_prev = '0;
        for (int i = 0; i < 5; i++) begin
            t6_cmd = 8'($urandom);
            run_txn(t6_cmd, t6_prev ^ 8'hFF, 1'b0);
            t6_prev = t6_cmd;
            step();
            check_output("t6_cnt", txn_cnt2, t6_seq[i]);
        end

        // Random traffic against the transaction model, then drain.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom),
                           (i < 700) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3 * LAT; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
        end
        check_output("drain_idle", busy, 0);
        check_output("drain_rsp", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
